// File: rtl/rx_frame_pkg.sv
// Shared frame layout constants and types for the receive-side frame buffer.
package rx_frame_pkg;

    localparam int FRAME_W   = 10;
    localparam int START_IDX = 0;
    localparam int STOP_IDX  = 9;
    localparam int DATA_LSB  = 1;
    localparam int DATA_W    = 8;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [DATA_W-1:0]  payload_t;

endpackage

// File: rtl/rx_frame_buffer_fifo.sv
// Show-ahead synchronous FIFO: registered head output, simultaneous push/pop,
// and a drop indication when a push meets a full FIFO with no pop.
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [DATA_W-1:0] head_reg, head_next;
    logic              do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees the head slot this cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    assign count_next  = count_reg + CW'(do_push) - CW'(do_pop);

    // Head register looks ahead; bypass the write when it lands on the new head.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (do_push && (wr_ptr_reg == rd_ptr_next))
            head_next = wr_data;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign rd_data = head_reg;
    assign count   = count_reg;

endmodule

// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: edge-detects frame/read strobes, optionally validates
// start/stop bits (RX_FRAME_CHECK_EN), and queues payloads in a show-ahead FIFO.
module rx_frame_buffer import rx_frame_pkg::*; #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 8,
    parameter int FRAME_W = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    char_received,
    input  logic [FRAME_W-1:0]      frame_in,
    input  logic                    rd_req,
    input  logic                    clear_flags,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [7:0]              frame_err_cnt
);

    logic cr_q, rq_q;
    logic push_ev, pop_ev;
    logic frame_ok, accept;
    logic empty, drop;
    logic overflow_reg;

    // Edge registers reset high so inputs already asserted at release are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cr_q <= 1'b1;
            rq_q <= 1'b1;
        end else begin
            cr_q <= char_received;
            rq_q <= rd_req;
        end
    end

    assign push_ev = char_received & ~cr_q;
    assign pop_ev  = rd_req & ~rq_q;

`ifdef RX_FRAME_CHECK_EN
    logic [7:0] err_cnt_reg;

    assign frame_ok = ~frame_in[START_IDX] & frame_in[STOP_IDX];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt_reg <= '0;
        else if (clear_flags)
            err_cnt_reg <= '0;
        else if (push_ev && !frame_ok && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;
    end

    assign frame_err_cnt = err_cnt_reg;
`else
    logic unused_frame_bits;

    assign unused_frame_bits = frame_in[START_IDX] ^ frame_in[STOP_IDX];
    assign frame_ok          = 1'b1;
    assign frame_err_cnt     = 8'd0;
`endif

    assign accept = push_ev & frame_ok;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .pop     (pop_ev),
        .wr_data (frame_in[DATA_LSB +: DATA_W]),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .drop    (drop)
    );

    // Clear wins over a same-cycle overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow_reg <= 1'b0;
        else if (clear_flags)
            overflow_reg <= 1'b0;
        else if (drop)
            overflow_reg <= 1'b1;
    end

    assign overflow = overflow_reg;
    assign rd_valid = ~empty;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed self-checking bench for rx_frame_buffer (DEPTH=8); expectations
// for framing follow RX_FRAME_CHECK_EN.
module tb_rx_frame_buffer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       char_received = 1'b0;
    logic [9:0] frame_in = '0;
    logic       rd_req = 1'b0;
    logic       clear_flags = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] frame_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    rx_frame_buffer #(.DEPTH(8), .DATA_W(8), .FRAME_W(10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .char_received (char_received),
        .frame_in      (frame_in),
        .rd_req        (rd_req),
        .clear_flags   (clear_flags),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [9:0] f);
        frame_in      = f;
        char_received = 1'b1;
        tick();
        char_received = 1'b0;
        tick();
        $display("push frame=0x%03h count=%0d", f, count);
    endtask

    task automatic pop_one();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        $display("pop  count=%0d rd_valid=%0b rd_data=0x%02h", count, rd_valid, rd_data);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({rd_valid, full, overflow} !== 3'b000 || count !== 4'd0 ||
            frame_err_cnt !== 8'd0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state got valid=%0b full=%0b ovf=%0b cnt=%0d err=%0d data=0x%02h want all 0",
                     rd_valid, full, overflow, count, frame_err_cnt, rd_data);
        end
    endtask

    task automatic test_basic_order();
        logic [7:0] exp_data [3] = '{8'h55, 8'hFF, 8'h01};
        push_frame(10'h2AA);
        push_frame(10'h3FE);
        push_frame(10'h202);
        vectors++;
        if (count !== 4'd3 || rd_data !== 8'h55) begin
            miscompares++;
            $display("FAIL basic_fill got cnt=%0d data=0x%02h want cnt=3 data=0x55", count, rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data[i]) begin
                miscompares++;
                $display("FAIL basic_order[%0d] got valid=%0b data=0x%02h want valid=1 data=0x%02h",
                         i, rd_valid, rd_data, exp_data[i]);
            end
            pop_one();
        end
        vectors++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_empty got valid=%0b cnt=%0d want valid=0 cnt=0", rd_valid, count);
        end
    endtask

    task automatic test_level_inputs();
        frame_in      = 10'h2AA;
        char_received = 1'b1;
        repeat (5) tick();
        char_received = 1'b0;
        tick();
        vectors++;
        if (count !== 4'd1 || rd_data !== 8'h55) begin
            miscompares++;
            $display("FAIL level_push got cnt=%0d data=0x%02h want cnt=1 data=0x55", count, rd_data);
        end
        push_frame(10'h3FE);
        rd_req = 1'b1;
        repeat (5) tick();
        rd_req = 1'b0;
        tick();
        vectors++;
        if (count !== 4'd1 || rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL level_pop got cnt=%0d data=0x%02h want cnt=1 data=0xff", count, rd_data);
        end
        pop_one();
    endtask

    task automatic test_overflow_and_full_pop();
        for (int i = 1; i <= 9; i++)
            push_frame({1'b1, 8'(i), 1'b0});
        vectors++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || rd_data !== 8'h01) begin
            miscompares++;
            $display("FAIL overflow got cnt=%0d full=%0b ovf=%0b data=0x%02h want cnt=8 full=1 ovf=1 data=0x01",
                     count, full, overflow, rd_data);
        end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        tick();
        vectors++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL clear_ovf got ovf=%0b cnt=%0d want ovf=0 cnt=8", overflow, count);
        end
        // Simultaneous push and pop on a full FIFO.
        frame_in      = {1'b1, 8'hA5, 1'b0};
        char_received = 1'b1;
        rd_req        = 1'b1;
        tick();
        char_received = 1'b0;
        rd_req        = 1'b0;
        tick();
        $display("push+pop frame=0x%03h count=%0d rd_data=0x%02h", frame_in, count, rd_data);
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1 || rd_data !== 8'h02) begin
            miscompares++;
            $display("FAIL full_pop got cnt=%0d ovf=%0b full=%0b data=0x%02h want cnt=8 ovf=0 full=1 data=0x02",
                     count, overflow, full, rd_data);
        end
        // Drain: 2..8 (8th push kept at slot 7, 9th lost), then the new tail byte.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i < 7) ? 8'(i + 2) : 8'hA5;
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                miscompares++;
                $display("FAIL drain[%0d] got valid=%0b data=0x%02h want valid=1 data=0x%02h",
                         i, rd_valid, rd_data, exp);
            end
            pop_one();
        end
        vectors++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty got valid=%0b cnt=%0d want valid=0 cnt=0", rd_valid, count);
        end
    endtask

    task automatic test_framing();
        logic [3:0] exp_cnt;
        logic [7:0] exp_err;
`ifdef RX_FRAME_CHECK_EN
        exp_cnt = 4'd0;
        exp_err = 8'd2;
`else
        exp_cnt = 4'd2;
        exp_err = 8'd0;
`endif
        push_frame(10'h2AB);
        push_frame(10'h0AA);
        vectors++;
        if (count !== exp_cnt || frame_err_cnt !== exp_err) begin
            miscompares++;
            $display("FAIL framing got cnt=%0d err=%0d want cnt=%0d err=%0d",
                     count, frame_err_cnt, exp_cnt, exp_err);
        end
`ifdef RX_FRAME_CHECK_EN
        for (int i = 0; i < 260; i++) begin
            frame_in      = 10'h0AA;
            char_received = 1'b1;
            tick();
            char_received = 1'b0;
            tick();
        end
        vectors++;
        if (frame_err_cnt !== 8'hFF || count !== 4'd0) begin
            miscompares++;
            $display("FAIL err_saturate got err=%0d cnt=%0d want err=255 cnt=0", frame_err_cnt, count);
        end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        tick();
        vectors++;
        if (frame_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL err_clear got err=%0d want 0", frame_err_cnt);
        end
`else
        vectors++;
        if (rd_data !== 8'h55) begin
            miscompares++;
            $display("FAIL framing_head got data=0x%02h want 0x55", rd_data);
        end
        pop_one();
        pop_one();
`endif
    endtask

    task automatic test_reset_and_empty_pop();
        for (int i = 0; i < 4; i++)
            push_frame({1'b1, 8'(8'h10 + i), 1'b0});
        vectors++;
        if (count !== 4'd4) begin
            miscompares++;
            $display("FAIL pre_reset_count got %0d want 4", count);
        end
        // Assert reset between edges and hold char_received high across release.
        #2;
        reset_n       = 1'b0;
        frame_in      = 10'h2AA;
        char_received = 1'b1;
        #1;
        vectors++;
        if ({rd_valid, full, overflow} !== 3'b000 || count !== 4'd0 ||
            frame_err_cnt !== 8'd0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset got valid=%0b full=%0b ovf=%0b cnt=%0d err=%0d data=0x%02h want all 0",
                     rd_valid, full, overflow, count, frame_err_cnt, rd_data);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL no_spurious_push got cnt=%0d want 0", count);
        end
        char_received = 1'b0;
        tick();
        pop_one();
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || frame_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL empty_pop got cnt=%0d valid=%0b ovf=%0b err=%0d want 0 0 0 0",
                     count, rd_valid, overflow, frame_err_cnt);
        end
        push_frame(10'h3FE);
        vectors++;
        if (count !== 4'd1 || rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL post_reset_push got cnt=%0d data=0x%02h want cnt=1 data=0xff", count, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_level_inputs();
        test_overflow_and_full_pop();
        test_framing();
        test_reset_and_empty_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
